decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational control decoder: sits between fetch and execute.
//  Accepts instructions over valid/ready, decodes them through the ctrl_decode sub-module into a packed control bundle,
//  and buffers bundles in a DEPTH-entry FIFO. Adds a halt/drain state machine, one-cycle createdump, flush and
//  illegal-opcode tagging.
// PARAMETERS
//  INSTR_W  16  instruction width; opcode = instr[INSTR_W-1 -: 5], func = instr[1:0]
//  PC_W     16  width of the PC carried alongside each instruction
//  DEPTH    2   output FIFO entries (1..4); DEPTH=2 gives full throughput
//  EXC_EN   1   1: unlisted opcodes tagged illegal and squashed; 0: decoded as NOP (all bundle fields default)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        fetch presents instr/pc
//  in_ready     out  1        block can accept this cycle
//  in_instr     in   INSTR_W  instruction word
//  in_pc        in   PC_W     PC of instruction
//  flush        in   1        synchronous squash of all buffered entries
//  out_valid    out  1        head entry valid
//  out_ready    in   1        execute consumes head
//  out_ctrl     out  CTRL_W   packed control bundle (layout in ctrl_pkg)
//  out_instr    out  INSTR_W  instruction of head entry
//  out_pc       out  PC_W     PC of head entry
//  createdump   out  1        one-cycle pulse when HALT retires
//  halted       out  1        sticky: processor halted
//  err_illegal  out  1        one-cycle pulse when an illegal entry is popped
//  occupancy    out  CNT_W    entries held, CNT_W = $clog2(DEPTH+1)
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, pointers 0, state RUN, out_valid=0, createdump=0, halted=0, err_illegal=0,
//   occupancy=0. After release: in_ready=1.
//  Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  in_ready = (state==RUN) & (occupancy<DEPTH) & ~flush. A push when full is refused even if a pop happens the same cycle.
//  Latency: a pushed entry is visible at out_* on the next cycle when the FIFO was empty. Otherwise order is strict FIFO.
//  out_* hold stable while out_valid & ~out_ready.
//  Pointers wrap modulo DEPTH. Simultaneous push and pop leaves occupancy unchanged.
//  Decode: ctrl_decode reproduces the existing opcode table (HALT, NOP, ALU-imm, shifts, ST/LD/STU, BTR, R-type,
//   compares, branches, LBI/SLBI, J/JR/JAL/JALR). Extra bundle bits: is_halt and illegal.
//  Illegal (EXC_EN=1): opcode not in table -> illegal=1, and reg_w_en, write_mem, read_mem, branch_I and branch_J forced 0.
//  FSM:
//   RUN    -> DRAIN on push of HALT (instr opcode 00000); no further pushes.
//   DRAIN  -> HALTED on pop of the is_halt entry. Next cycle: createdump=1 for exactly 1 cycle and halted=1.
//   DRAIN  -> RUN on flush; the HALT was speculative and is discarded with no dump.
//   HALTED -> terminal until rst_n; in_ready=0, out_valid=0, flush ignored.
//  flush (RUN/DRAIN): next edge empties the FIFO, so out_valid=0 the following cycle. A pop in the flush cycle still
//   completes. in_valid in the flush cycle is dropped (in_ready=0).
//  err_illegal: registered pulse, cycle after popping an illegal entry. Entries flushed before popping raise no error.
//  Reset mid-DRAIN or mid-HALTED returns to RUN with an empty FIFO; no createdump.
// STRUCTURE
//  ctrl_pkg: opcode localparams (OP_HALT=5'b00000 ... OP_JALR=5'b00111), ALU_op codes,
//   bundle field offsets/CTRL_W, FSM state encoding.
//  ctrl_decode: purely combinational instr -> bundle, one instance. FIFO storage, FSM and pulses live in the top level.
// TESTING
//  1 Stream 4'h4 ADDI words 16'h4123,16'h4124,... with out_ready=1 -> one out per cycle, 1-cycle latency, PCs in order.
//  2 Hold out_ready=0, push 3 instrs (DEPTH=2) -> in_ready=0 after 2, occupancy=2, 3rd held; release -> order preserved.
//  3 Push 16'h4100 then 16'h0000 (HALT) then 16'h4200 -> 3rd refused; HALT pop -> createdump 1 cycle,
//   halted=1, in_ready=0 forever.
//  4 HALT buffered with out_ready=0, assert flush -> FIFO empty, state RUN, no createdump, next push accepted.
//  5 EXC_EN=1, push 16'h1000 (opcode 00010) -> reg_w_en=0, write_mem=0, illegal=1; err_illegal pulses cycle after pop.
//  6 rst_n low mid-DRAIN with occupancy=2 -> immediately out_valid=0, occupancy=0; after release in_ready=1.

Source files
------------

// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared definitions for the registered control decoder: opcode map,
// ALU operation codes, control bundle layout and pipe FSM states.
package ctrl_pkg;

    // Opcode map, instr[INSTR_W-1 -: 5]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // ALU operations; the low two bits of the R-type groups equal func
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_XOR   = 4'd2,
        ALU_ANDN  = 4'd3,
        ALU_ROL   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_ROR   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SEQ   = 4'd8,
        ALU_SLT   = 4'd9,
        ALU_SLE   = 4'd10,
        ALU_SCO   = 4'd11,
        ALU_BTR   = 4'd12,
        ALU_PASSB = 4'd13,
        ALU_SLBI  = 4'd14
    } alu_op_t;

    // Destination register select
    typedef enum logic [1:0] {
        DST_RD = 2'd0,   // instr[4:2]
        DST_RT = 2'd1,   // instr[7:5]
        DST_RS = 2'd2,   // instr[10:8]
        DST_R7 = 2'd3    // link register
    } reg_dst_t;

    // Control bundle, MSB first
    typedef struct packed {
        alu_op_t  alu_op;       // [16:13]
        reg_dst_t reg_dst;      // [12:11]
        logic     imm_zext;     // [10]
        logic     alu_src_imm;  // [9]
        logic     link;         // [8]
        logic     jump_reg;     // [7]
        logic     branch_J;     // [6]
        logic     branch_I;     // [5]
        logic     read_mem;     // [4]
        logic     write_mem;    // [3]
        logic     reg_w_en;     // [2]
        logic     is_halt;      // [1]
        logic     illegal;      // [0]
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Bit offsets of the flat bundle for consumers not importing ctrl_t
    localparam int CTRL_ILLEGAL_BIT   = 0;
    localparam int CTRL_IS_HALT_BIT   = 1;
    localparam int CTRL_REG_W_EN_BIT  = 2;
    localparam int CTRL_WRITE_MEM_BIT = 3;
    localparam int CTRL_READ_MEM_BIT  = 4;
    localparam int CTRL_BRANCH_I_BIT  = 5;
    localparam int CTRL_BRANCH_J_BIT  = 6;
    localparam int CTRL_JUMP_REG_BIT  = 7;
    localparam int CTRL_LINK_BIT      = 8;
    localparam int CTRL_ALU_SRC_BIT   = 9;
    localparam int CTRL_IMM_ZEXT_BIT  = 10;
    localparam int CTRL_REG_DST_LSB   = 11;
    localparam int CTRL_ALU_OP_LSB    = 13;

    // Pipe state machine
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// Combinational instruction -> control bundle decoder.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int EXC_EN  = 1
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);

    logic [4:0] opcode;
    logic [1:0] func;
    logic       legal;
    ctrl_t      dec;
    logic       unused_fields;

    assign opcode = instr[INSTR_W-1 -: 5];
    assign func   = instr[1:0];

    // Register fields are consumed downstream, not by the decoder
    assign unused_fields = ^instr[INSTR_W-6:2];

    // Opcode table lookup; unlisted opcodes yield an all-default bundle
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OP_HALT: dec.is_halt = 1'b1;
            OP_NOP: ;
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_RT;
                dec.alu_op      = alu_op_t'({2'b00, opcode[1:0]});
                dec.imm_zext    = opcode[1];
            end
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_RT;
                dec.alu_op      = alu_op_t'({2'b01, opcode[1:0]});
            end
            OP_ST: begin
                dec.write_mem   = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OP_LD: begin
                dec.read_mem    = 1'b1;
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_RT;
            end
            OP_STU: begin
                dec.write_mem   = 1'b1;
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_RS;
            end
            OP_BTR: begin
                dec.reg_w_en = 1'b1;
                dec.reg_dst  = DST_RD;
                dec.alu_op   = ALU_BTR;
            end
            OP_ALU: begin
                dec.reg_w_en = 1'b1;
                dec.reg_dst  = DST_RD;
                dec.alu_op   = alu_op_t'({2'b00, func});
            end
            OP_SHIFT: begin
                dec.reg_w_en = 1'b1;
                dec.reg_dst  = DST_RD;
                dec.alu_op   = alu_op_t'({2'b01, func});
            end
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                dec.reg_w_en = 1'b1;
                dec.reg_dst  = DST_RD;
                dec.alu_op   = alu_op_t'({2'b10, opcode[1:0]});
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: dec.branch_I = 1'b1;
            OP_LBI: begin
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_RS;
                dec.alu_op      = ALU_PASSB;
            end
            OP_SLBI: begin
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm_zext    = 1'b1;
                dec.reg_dst     = DST_RS;
                dec.alu_op      = ALU_SLBI;
            end
            OP_J: dec.branch_J = 1'b1;
            OP_JR: begin
                dec.jump_reg    = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OP_JAL: begin
                dec.branch_J = 1'b1;
                dec.link     = 1'b1;
                dec.reg_w_en = 1'b1;
                dec.reg_dst  = DST_R7;
            end
            OP_JALR: begin
                dec.jump_reg    = 1'b1;
                dec.link        = 1'b1;
                dec.reg_w_en    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.reg_dst     = DST_R7;
            end
            default: legal = 1'b0;
        endcase
        // Unlisted opcode: every side effect squashed, optionally tagged
        if (!legal) begin
            dec = '0;
            if (EXC_EN != 0) dec.illegal = 1'b1;
        end
    end

    assign ctrl = dec;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered control decoder between fetch and execute: decode, buffer in
// a small FIFO, and manage HALT drain / createdump / flush.
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 2,
    parameter int EXC_EN  = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               createdump,
    output logic               halted,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t             state;
    state_t             next_state;
    ctrl_t              dec_ctrl;
    ctrl_t              head_ctrl;
    ctrl_t              mem_ctrl  [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               accept_en;
    logic               deliver_en;
    logic               flush_en;
    logic               push;
    logic               pop;

    ctrl_decode #(
        .INSTR_W (INSTR_W),
        .EXC_EN  (EXC_EN)
    ) u_decode (
        .instr (in_instr),
        .ctrl  (dec_ctrl)
    );

    assign head_ctrl = mem_ctrl[rd_ptr];
    assign in_ready  = accept_en & (count < CNT_W'(DEPTH)) & ~flush;
    assign out_valid = deliver_en & (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_ctrl  = head_ctrl;
    assign out_instr = mem_instr[rd_ptr];
    assign out_pc    = mem_pc[rd_ptr];
    assign occupancy = count;
    assign halted    = (state == ST_HALTED);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= next_state;
    end

    // FSM next state: flush beats a same-cycle HALT pop, since the HALT was speculative
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:    if (push && dec_ctrl.is_halt) next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (flush)                        next_state = ST_RUN;
                else if (pop && head_ctrl.is_halt) next_state = ST_HALTED;
            end
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_RUN;
        endcase
    end

    // FSM outputs: which FIFO ports are open in each state
    always_comb begin
        accept_en  = 1'b0;
        deliver_en = 1'b0;
        flush_en   = 1'b0;
        case (state)
            ST_RUN: begin
                accept_en  = 1'b1;
                deliver_en = 1'b1;
                flush_en   = flush;
            end
            ST_DRAIN: begin
                deliver_en = 1'b1;
                flush_en   = flush;
            end
            default: ;
        endcase
    end

    // FIFO payload storage, written on push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ctrl[wr_ptr]  <= dec_ctrl;
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    // FIFO pointers and occupancy; flush resets them to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One-cycle pulses following the retiring pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            createdump  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            createdump  <= (state == ST_DRAIN) && (next_state == ST_HALTED);
            err_illegal <= pop & head_ctrl.illegal;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe (DEPTH=2, EXC_EN=1).
module tb_decode_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    // Hand-built bundles (alu_op[16:13] dst[12:11] zext[10] imm[9] link[8]
    // jreg[7] bJ[6] bI[5] rd[4] wr[3] regw[2] halt[1] illegal[0])
    localparam logic [16:0] C_ADDI    = 17'h00A04;
    localparam logic [16:0] C_HALT    = 17'h00002;
    localparam logic [16:0] C_ILLEGAL = 17'h00001;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr = '0;
    logic [PC_W-1:0]    in_pc = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               createdump;
    logic               halted;
    logic               err_illegal;
    logic [CNT_W-1:0]   occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH),
        .EXC_EN  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .createdump  (createdump),
        .halted      (halted),
        .err_illegal (err_illegal),
        .occupancy   (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL reset_createdump: got %b want 0", createdump); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_err_illegal: got %b want 0", err_illegal); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 16'h4123 + 16'(i);
            in_pc    = 16'h0100 + 16'(2 * i);
            tick();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            n_tests++; if (out_instr !== 16'h4123 + 16'(i)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, 16'h4123 + 16'(i)); end
            n_tests++; if (out_pc !== 16'h0100 + 16'(2 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 16'h0100 + 16'(2 * i)); end
            n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
            n_tests++; if (out_ctrl !== C_ADDI) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, C_ADDI); end
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b want 0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_end_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h4300; in_pc = 16'h0200;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty: got %b want 1", in_ready); end
        tick();
        in_instr = 16'h4301; in_pc = 16'h0202;
        tick();
        in_instr = 16'h4302; in_pc = 16'h0204;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d want 2", occupancy); end
        tick();
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_hold: got %0d want 2", occupancy); end
        n_tests++; if (out_instr !== 16'h4300) begin n_fail++; $display("FAIL bp_head_hold: got %h want 4300", out_instr); end
        n_tests++; if (out_pc !== 16'h0200) begin n_fail++; $display("FAIL bp_pc_hold: got %h want 0200", out_pc); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full_pop: got %b want 0", in_ready); end
        tick();
        n_tests++; if (out_instr !== 16'h4301) begin n_fail++; $display("FAIL bp_second: got %h want 4301", out_instr); end
        n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_after_pop: got %0d want 1", occupancy); end
        tick();
        n_tests++; if (out_instr !== 16'h4302) begin n_fail++; $display("FAIL bp_third: got %h want 4302", out_instr); end
        n_tests++; if (out_pc !== 16'h0204) begin n_fail++; $display("FAIL bp_third_pc: got %h want 0204", out_pc); end
        n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_pushpop: got %0d want 1", occupancy); end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_halt();
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 16'h4100; in_pc = 16'h0300;
        tick();
        in_instr = 16'h0000; in_pc = 16'h0302;
        tick();
        n_tests++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL halt_head: got %h want 0000", out_instr); end
        n_tests++; if (out_ctrl !== C_HALT) begin n_fail++; $display("FAIL halt_ctrl: got %h want %h", out_ctrl, C_HALT); end
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL halt_dump_early: got %b want 0", createdump); end
        in_instr = 16'h4200; in_pc = 16'h0304;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_drain_refuse: got %b want 0", in_ready); end
        tick();
        n_tests++; if (createdump !== 1'b1) begin n_fail++; $display("FAIL halt_dump: got %b want 1", createdump); end
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_out_valid: got %b want 0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL halt_occ: got %0d want 0", occupancy); end
        tick();
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL halt_dump_once: got %b want 0", createdump); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flush_ignored: got %b want 1", halted); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready[%0d]: got %b want 0", i, in_ready); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 0", i, out_valid); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h0000; in_pc = 16'h0400;
        tick();
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_halt_buffered: got %b want 1", out_valid); end
        flush = 1'b1; in_valid = 1'b1; in_instr = 16'h4500;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL flush_dump: got %b want 0", createdump); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL flush_halted: got %b want 0", halted); end
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_run_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_instr = 16'h4400; in_pc = 16'h0410;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_instr !== 16'h4400) begin n_fail++; $display("FAIL flush_next_push: got %h want 4400", out_instr); end
        n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL flush_next_occ: got %0d want 1", occupancy); end
        tick();
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL flush_no_dump: got %b want 0", createdump); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_final_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1000; in_pc = 16'h0500;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_ctrl !== C_ILLEGAL) begin n_fail++; $display("FAIL ill_ctrl: got %h want %h", out_ctrl, C_ILLEGAL); end
        n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_err_early: got %b want 0", err_illegal); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 1", err_illegal); end
        tick();
        n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_err_once: got %b want 0", err_illegal); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1000; in_pc = 16'h0502;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_flushed_err: got %b want 0", err_illegal); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL ill_flushed_occ: got %0d want 0", occupancy); end
        tick();
        n_tests++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_flushed_err2: got %b want 0", err_illegal); end
    endtask

    task automatic test_decode();
        logic [15:0] ins [6] = '{16'h0800, 16'h8000, 16'h8800, 16'h3000, 16'hD801, 16'hA800};
        logic [16:0] exp [6] = '{17'h00000, 17'h00208, 17'h00A14, 17'h01944, 17'h02004, 17'h0AA04};
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc = 16'h0600 + 16'(2 * i);
            tick();
            n_tests++; if (out_ctrl !== exp[i]) begin n_fail++; $display("FAIL decode[%h]: got %h want %h", ins[i], out_ctrl, exp[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_drain();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h4100; in_pc = 16'h0700;
        tick();
        in_instr = 16'h0000; in_pc = 16'h0702;
        tick();
        in_valid = 1'b0;
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rstd_occ_pre: got %0d want 2", occupancy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstd_valid: got %b want 0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rstd_occ: got %0d want 0", occupancy); end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstd_ready: got %b want 1", in_ready); end
        tick();
        n_tests++; if (createdump !== 1'b0) begin n_fail++; $display("FAIL rstd_dump: got %b want 0", createdump); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rstd_halted: got %b want 0", halted); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_flush();
        test_illegal();
        test_decode();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
